gf251_inv: RTL
==============

GF251_INV -- requirements
Module: gf251_inv

Interface
Parameters: none.
REQ-001 SHALL provide port i_clk  input  1  single clock; all flops rising-edge.
REQ-002 SHALL provide port i_rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL provide port i_start  input  1  request; sampled only while idle.
REQ-004 SHALL provide port i_a  input  8  operand; sampled with i_start.
REQ-005 SHALL provide port o_c  output  8  result a^-1 mod 251, canonical 0..250.
REQ-006 SHALL provide port o_done  output  1  one-cycle pulse; o_c valid from this cycle.
REQ-007 SHALL provide port o_busy  output  1  high from the cycle after i_start acceptance until the o_done cycle, inclusive.

Function
REQ-008 SHALL compute c = a^249 mod 251 (Fermat inverse); a = 0 SHALL yield c = 0, with no error flag.
REQ-009 SHALL map i_a values 251..255 to i_a - 251 at capture; 251 SHALL therefore yield 0.
REQ-010 SHALL use left-to-right square-and-multiply over exponent bits 7..0 of 249 (11111001b), with acc initialised to 1.
REQ-011 SHALL perform, for every bit, one square (acc = acc*acc mod 251), then one multiply (acc = acc*a mod 251) only when the bit is 1: 8 squares and 6 multiplies in total.
REQ-012 SHALL NOT skip the leading square of 1; the schedule SHALL be fixed and data-independent for constant time.
REQ-013 SHALL implement each modular operation as 4 cycles: cycle 1 registers the 16-bit product; cycles 2-4 perform Barrett reduction (q = (p*262)>>16, r = p - 251q, then add 251 if negative).
REQ-014 SHALL use a single shared 8x8 multiplier and reducer, with no overlap between operations.
REQ-015 SHALL use FSM states IDLE, LOAD, SQR, MUL, DONE, with these transitions:
  - IDLE->LOAD on i_start.
  - LOAD->SQR after one cycle.
  - SQR->MUL when the current bit is 1.
  - SQR->SQR (next bit) when the current bit is 0 and the bit index is greater than 0.
  - MUL->SQR when the bit index is greater than 0.
  - SQR or MUL->DONE after bit 0 completes.
  - DONE->IDLE after one cycle.
REQ-016 SHALL track position with a 3-bit bit-index counter (7 down to 0) and a 2-bit op-phase counter (0..3).
REQ-017 SHALL have a latency of 58 cycles: when i_start is sampled at edge 0, o_done SHALL be high after edge 58 and low after edge 59.
REQ-018 SHALL allow a new i_start on the cycle o_done is high; that start SHALL NOT be accepted, and acceptance SHALL happen no earlier than the following cycle.
REQ-019 SHALL ignore i_start while o_busy is high; the in-flight result SHALL be unaffected and no second o_done SHALL be produced.
REQ-020 SHALL hold o_c stable from o_done until the next o_done; o_c SHALL change only in the o_done cycle.
REQ-021 SHALL never drive o_c above 250; every intermediate acc SHALL be in 0..250.

Reset
REQ-022 SHALL, while i_rst = 1, drive o_c = 0, o_done = 0 and o_busy = 0, put the FSM in IDLE, and clear both counters, acc and the operand register.
REQ-023 SHALL treat assertion of i_rst mid-operation as an abort: no o_done for the aborted request, and the block SHALL be idle on the first edge after deassertion.
REQ-024 SHALL accept i_start on the first rising edge at which i_rst is low.

Verification
REQ-025 SHALL verify known inverses: i_a = 1 -> o_c = 1; 2 -> 126; 3 -> 84; 250 -> 250. Each SHALL have o_done exactly 58 cycles after start.
REQ-026 SHALL verify boundary operands: i_a = 0 -> 0; 251 -> 0; 253 -> 126. All SHALL have the same 58-cycle latency.
REQ-027 SHALL verify exhaustive coverage: for all i_a in 1..250, o_c*i_a mod 251 = 1, with back-to-back requests issued one cycle after each o_done.
REQ-028 SHALL verify that busy starts are ignored: start with a = 2, pulse i_start with a = 3 at cycle 10 -> exactly one o_done with o_c = 126, and o_busy stays high throughout.
REQ-029 SHALL verify mid-operation reset: start with a = 5, assert i_rst at cycle 20 for 2 cycles -> o_c = 0, no o_done; a new start with a = 5 -> o_c = 201 (5*201 = 1005 = 1 mod 251).

Source files
------------

// File: rtl/gf251_inv.sv
// gf251_inv: multiplicative inverse in GF(251) via Fermat's little theorem.
// c = a^249 mod 251 is computed by left-to-right square-and-multiply over the
// fixed exponent 8'b1111_1001. One shared 8x8 multiplier and a Barrett reducer
// are time-shared; every modular operation takes exactly four cycles.
// The schedule never depends on the operand, so the block runs in constant time.
//
// Handshake: i_start is a one-cycle request, taken only while o_busy is low.
// i_a is captured with it. o_busy stays high from the cycle after acceptance
// up to and including the cycle where o_done pulses. o_c is valid from o_done
// and holds until the next o_done.
module gf251_inv (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_a,
  output logic [7:0] o_c,
  output logic       o_done,
  output logic       o_busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_SQR  = 3'd2,
    S_MUL  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // p - 2 = 249, scanned from bit 7 down to bit 0
  localparam logic [7:0] EXP_BITS = 8'hF9;

  state_t      state_q, state_d;
  logic        req_q, req_d;      // request accepted, LOAD follows next cycle
  logic [7:0]  a_q, a_d;          // canonical operand 0..250
  logic [7:0]  acc_q, acc_d;      // running power, always 0..250
  logic [2:0]  bit_q, bit_d;      // exponent bit index, 7 down to 0
  logic [1:0]  ph_q, ph_d;        // phase within one modular operation
  logic [15:0] p_q, p_d;          // raw 16-bit product
  logic [7:0]  q_q, q_d;          // Barrett quotient estimate
  logic [9:0]  r_q, r_d;          // signed remainder, -250..250
  logic [7:0]  c_q, c_d;          // published result

  logic [7:0]  mul_b;
  logic [15:0] prod;
  logic [7:0]  q_est;
  logic [9:0]  r_est;
  logic [7:0]  acc_new;
  logic [7:0]  a_canon;

  // Shared datapath: multiplier, Barrett quotient, remainder, final correction
  always_comb begin
    mul_b   = (state_q == S_MUL) ? a_q : acc_q;
    prod    = {8'd0, acc_q} * {8'd0, mul_b};
    // 262/2^16 slightly overestimates 1/251, so q is exact or one too large
    q_est   = 8'(({8'd0, p_q} * 24'd262) >> 16);
    r_est   = 10'({1'b0, p_q} - (17'(q_q) * 17'd251));
    acc_new = 8'(r_q[9] ? (r_q + 10'd251) : r_q);
    a_canon = (i_a >= 8'd251) ? (i_a - 8'd251) : i_a;
  end

  // Next-state logic: request capture, operation sequencing, result publication
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    a_d     = a_q;
    acc_d   = acc_q;
    bit_d   = bit_q;
    ph_d    = ph_q;
    p_d     = p_q;
    q_d     = q_q;
    r_d     = r_q;
    c_d     = c_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_q) begin
          req_d   = 1'b0;
          state_d = S_LOAD;
        end else if (i_start) begin
          req_d = 1'b1;
          a_d   = a_canon;
        end
      end
      S_LOAD: begin
        acc_d   = 8'd1;
        bit_d   = 3'd7;
        ph_d    = 2'd0;
        state_d = S_SQR;
      end
      S_SQR, S_MUL: begin
        ph_d = ph_q + 2'd1;
        unique case (ph_q)
          2'd0: p_d = prod;
          2'd1: q_d = q_est;
          2'd2: r_d = r_est;
          default: begin
            acc_d = acc_new;
            if ((state_q == S_SQR) && EXP_BITS[bit_q]) begin
              state_d = S_MUL;
            end else if (bit_q != 3'd0) begin
              bit_d   = bit_q - 3'd1;
              state_d = S_SQR;
            end else begin
              c_d     = acc_new;
              state_d = S_DONE;
            end
          end
        endcase
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      a_q     <= 8'd0;
      acc_q   <= 8'd0;
      bit_q   <= 3'd0;
      ph_q    <= 2'd0;
      p_q     <= 16'd0;
      q_q     <= 8'd0;
      r_q     <= 10'd0;
      c_q     <= 8'd0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
      bit_q   <= bit_d;
      ph_q    <= ph_d;
      p_q     <= p_d;
      q_q     <= q_d;
      r_q     <= r_d;
      c_q     <= c_d;
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    o_c    = c_q;
    o_done = (state_q == S_DONE);
    o_busy = req_q || (state_q != S_IDLE);
  end

endmodule
